// File: rtl/multicycle_alu_ctrl.sv
`default_nettype none
// ============================================================================
// multicycle_alu_ctrl : multi-cycle control FSM driving the ALU op code,
//                       datapath enables and memory handshakes.
// Revision 1.0 - initial release
// ============================================================================
module multicycle_alu_ctrl #(
  parameter logic [5:0] SUBI_OPC   = 6'h18,
  parameter bit         ILLEGAL_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        zero,
  output logic [5:0]  alu_control_out,
  output logic        alu_src_b,
  output logic        imem_req,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_size,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        illegal,
  output logic [2:0]  state_out
);

  localparam logic [5:0] ALU_ADD  = 6'b000000;
  localparam logic [5:0] ALU_SUB  = 6'b000001;
  localparam logic [5:0] ALU_AND  = 6'b000010;
  localparam logic [5:0] ALU_NOR  = 6'b000011;
  localparam logic [5:0] ALU_OR   = 6'b000100;
  localparam logic [5:0] ALU_SLT  = 6'b000101;
  localparam logic [5:0] ALU_ADDI = 6'b000110;
  localparam logic [5:0] ALU_ANDI = 6'b000111;
  localparam logic [5:0] ALU_SUBI = 6'b001000;
  localparam logic [5:0] ALU_ORI  = 6'b001001;
  localparam logic [5:0] ALU_BEQ  = 6'b001010;
  localparam logic [5:0] ALU_BNEQ = 6'b001011;
  localparam logic [5:0] ALU_BGEZ = 6'b001100;
  localparam logic [5:0] ALU_SLTI = 6'b001101;
  localparam logic [5:0] ALU_LH   = 6'b001110;
  localparam logic [5:0] ALU_LW   = 6'b001111;
  localparam logic [5:0] ALU_LB   = 6'b010100;
  localparam logic [5:0] ALU_LUI  = 6'b010011;

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_NONE   = 3'd0,
    C_RTYPE  = 3'd1,
    C_ITYPE  = 3'd2,
    C_BRANCH = 3'd3,
    C_LOAD   = 3'd4,
    C_STORE  = 3'd5
  } class_t;

  state_t      state, state_nx;
  class_t      op_class, dec_class;
  logic [5:0]  ir_op, ir_funct, alu_code, dec_code;
  logic [4:0]  ir_rt;
  logic [1:0]  mem_sz, dec_size;
  logic        dec_illegal, class_srcb;
  logic        unused_instr_bits;

  // Only opcode, rt and funct steer control; the rest belongs to the datapath.
  assign unused_instr_bits = ^{instr[25:21], instr[15:6]};

  always_comb begin
    dec_class = C_NONE;
    dec_code  = ALU_ADD;
    dec_size  = 2'b00;
    if (ir_op == SUBI_OPC) begin
      dec_class = C_ITYPE; dec_code = ALU_SUBI;
    end else begin
      case (ir_op)
        6'h00: begin
          dec_class = C_RTYPE;
          case (ir_funct)
            6'h20:   dec_code = ALU_ADD;
            6'h22:   dec_code = ALU_SUB;
            6'h24:   dec_code = ALU_AND;
            6'h25:   dec_code = ALU_OR;
            6'h27:   dec_code = ALU_NOR;
            6'h2A:   dec_code = ALU_SLT;
            default: dec_class = C_NONE;
          endcase
        end
        6'h08: begin dec_class = C_ITYPE;  dec_code = ALU_ADDI; end
        6'h0C: begin dec_class = C_ITYPE;  dec_code = ALU_ANDI; end
        6'h0D: begin dec_class = C_ITYPE;  dec_code = ALU_ORI;  end
        6'h0A: begin dec_class = C_ITYPE;  dec_code = ALU_SLTI; end
        6'h0F: begin dec_class = C_ITYPE;  dec_code = ALU_LUI;  end
        6'h04: begin dec_class = C_BRANCH; dec_code = ALU_BEQ;  end
        6'h05: begin dec_class = C_BRANCH; dec_code = ALU_BNEQ; end
        6'h01: if (ir_rt == 5'd1) begin
                 dec_class = C_BRANCH; dec_code = ALU_BGEZ;
               end
        6'h20: begin dec_class = C_LOAD;  dec_code = ALU_LB; dec_size = 2'b00; end
        6'h21: begin dec_class = C_LOAD;  dec_code = ALU_LH; dec_size = 2'b01; end
        6'h23: begin dec_class = C_LOAD;  dec_code = ALU_LW; dec_size = 2'b10; end
        6'h2B: begin dec_class = C_STORE; dec_code = ALU_ADD; dec_size = 2'b10; end
        default: dec_class = C_NONE;
      endcase
    end
    if (dec_class == C_NONE) begin
      dec_code = ALU_ADD;
      dec_size = 2'b00;
    end
    dec_illegal = (dec_class == C_NONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_INIT;
      ir_op    <= 6'd0;
      ir_rt    <= 5'd0;
      ir_funct <= 6'd0;
      op_class <= C_NONE;
      alu_code <= ALU_ADD;
      mem_sz   <= 2'b00;
    end else begin
      state <= state_nx;
      if (state == S_FETCH && imem_ready) begin
        ir_op    <= instr[31:26];
        ir_rt    <= instr[20:16];
        ir_funct <= instr[5:0];
      end
      if (state == S_DECODE) begin
        op_class <= dec_class;
        alu_code <= dec_code;
        mem_sz   <= dec_size;
      end
    end
  end

  assign class_srcb = (op_class == C_ITYPE) || (op_class == C_LOAD) || (op_class == C_STORE);
  assign state_out  = state;

  always_comb begin
    state_nx        = state;
    alu_control_out = ALU_ADD;
    alu_src_b       = 1'b0;
    imem_req        = 1'b0;
    ir_write        = 1'b0;
    pc_write        = 1'b0;
    pc_src          = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_size        = 2'b00;
    reg_write       = 1'b0;
    reg_dst         = 1'b0;
    mem_to_reg      = 1'b0;
    illegal         = 1'b0;
    case (state)
      S_INIT: state_nx = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_nx = S_DECODE;
        end
      end
      S_DECODE: begin
        // With ILLEGAL_EN=0 an undecodable word simply retires as a NOP.
        if (dec_illegal) begin
          illegal  = ILLEGAL_EN;
          state_nx = S_FETCH;
        end else begin
          state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_control_out = alu_code;
        alu_src_b       = class_srcb;
        case (op_class)
          C_BRANCH: begin
            pc_write = zero;
            pc_src   = 1'b1;
            state_nx = S_FETCH;
          end
          C_LOAD, C_STORE: state_nx = S_MEM;
          default:         state_nx = S_WB;
        endcase
      end
      S_MEM: begin
        alu_control_out = alu_code;
        alu_src_b       = class_srcb;
        mem_read        = (op_class == C_LOAD);
        mem_write       = (op_class == C_STORE);
        mem_size        = mem_sz;
        if (dmem_ready)
          state_nx = (op_class == C_LOAD) ? S_WB : S_FETCH;
      end
      S_WB: begin
        alu_control_out = alu_code;
        alu_src_b       = class_srcb;
        reg_write       = 1'b1;
        reg_dst         = (op_class == C_RTYPE);
        mem_to_reg      = (op_class == C_LOAD);
        state_nx        = S_FETCH;
      end
      default: state_nx = S_INIT;
    endcase
  end

endmodule
`default_nettype wire
